// File: rtl/param_register_file.sv
// General/scratch register file: NUM_R general regs with a shadow bank for
// context save/restore, NUM_S scratch regs, two combinational read ports.

// One WIDTH-bit register applying the 8-op FunSel update when enabled, with a
// priority load path (used by the general regs for shadow restore).
module prf_cell #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       fun_sel,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] hi_keep;

    // Upper bits kept by the low-half load; at WIDTH=16 there is nothing above bit 15.
    generate
        if (WIDTH > 16) begin : g_hi
            assign hi_keep = {q[WIDTH-1:16], 16'h0000};
        end else begin : g_no_hi
            assign hi_keep = '0;
        end
    endgenerate

    // Next value selected by FunSel; arithmetic wraps modulo 2**WIDTH.
    always_comb begin
        nxt = q;
        case (fun_sel)
            3'b000:  nxt = q - WIDTH'(1);
            3'b001:  nxt = q + WIDTH'(1);
            3'b010:  nxt = din;
            3'b011:  nxt = '0;
            3'b100:  nxt = WIDTH'(din[7:0]);
            3'b101:  nxt = hi_keep | WIDTH'(din[15:0]);
            3'b110:  nxt = {q[WIDTH-9:0], din[7:0]};
            default: nxt = WIDTH'($signed(din[15:0]));
        endcase
    end

    // Register: load (restore) beats the enabled FunSel update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (load)
            q <= load_val;
        else if (en)
            q <= nxt;
    end
endmodule

module param_register_file #(
    parameter int WIDTH = 32,
    parameter int NUM_R = 4,
    parameter int NUM_S = 4,
    parameter int SELW  = 3
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] I,
    input  logic [2:0]       FunSel,
    input  logic [NUM_R-1:0] RegSel,
    input  logic [NUM_S-1:0] ScrSel,
    input  logic [SELW-1:0]  OutASel,
    input  logic [SELW-1:0]  OutBSel,
    input  logic             Save,
    input  logic             Restore,
    output logic [WIDTH-1:0] OutA,
    output logic [WIDTH-1:0] OutB
);
    localparam int NUM_T   = NUM_R + NUM_S;
    localparam int NUM_SEL = 2 ** SELW;

    // Index k holds R(k+1) / S(k+1); enable bits are MSB-first (bit N-1 = reg 1).
    logic [NUM_R-1:0][WIDTH-1:0]   r_q;
    logic [NUM_R-1:0][WIDTH-1:0]   shadow;
    logic [NUM_S-1:0][WIDTH-1:0]   s_q;
    logic [NUM_SEL-1:0][WIDTH-1:0] rd_tab;

    generate
        for (genvar k = 0; k < NUM_R; k++) begin : g_r
            prf_cell #(.WIDTH(WIDTH)) u_cell (
                .clk      (Clock),
                .rst      (Reset),
                .en       (RegSel[NUM_R-1-k]),
                .fun_sel  (FunSel),
                .din      (I),
                .load     (Restore),
                .load_val (shadow[k]),
                .q        (r_q[k])
            );
        end

        for (genvar k = 0; k < NUM_S; k++) begin : g_s
            prf_cell #(.WIDTH(WIDTH)) u_cell (
                .clk      (Clock),
                .rst      (Reset),
                .en       (ScrSel[NUM_S-1-k]),
                .fun_sel  (FunSel),
                .din      (I),
                .load     (1'b0),
                .load_val ('0),
                .q        (s_q[k])
            );
        end

        // Read table padded to every select code; unused codes read 0.
        for (genvar t = 0; t < NUM_SEL; t++) begin : g_rd
            if (t < NUM_R) begin : g_rd_r
                assign rd_tab[t] = r_q[t];
            end else if (t < NUM_T) begin : g_rd_s
                assign rd_tab[t] = s_q[t-NUM_R];
            end else begin : g_rd_z
                assign rd_tab[t] = '0;
            end
        end
    endgenerate

    // Shadow snapshot of pre-edge R values; with Restore the cells swap atomically.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            shadow <= '0;
        else if (Save)
            shadow <= r_q;
    end

    assign OutA = rd_tab[OutASel];
    assign OutB = rd_tab[OutBSel];
endmodule

// File: tb/tb_param_register_file.sv
module tb_param_register_file;
    logic        Clock = 1'b0;
    logic        Reset;
    logic [31:0] I;
    logic [2:0]  FunSel;
    logic [3:0]  RegSel, ScrSel;
    logic [2:0]  OutASel, OutBSel;
    logic        Save, Restore;
    logic [31:0] OutA, OutB;

    logic [15:0] b_I;
    logic [2:0]  b_FunSel;
    logic [7:0]  b_RegSel;
    logic [1:0]  b_ScrSel;
    logic [3:0]  b_OutASel, b_OutBSel;
    logic        b_Save, b_Restore;
    logic [15:0] b_OutA, b_OutB;

    int errors = 0;
    int checks = 0;

    // Reference state: index k = R(k+1), S(k+1), shadow of R(k+1)
    logic [31:0] mr [4];
    logic [31:0] ms [4];
    logic [31:0] msh [4];

    always #10 Clock = ~Clock;

    param_register_file dut (
        .Clock(Clock), .Reset(Reset), .I(I), .FunSel(FunSel), .RegSel(RegSel),
        .ScrSel(ScrSel), .OutASel(OutASel), .OutBSel(OutBSel), .Save(Save),
        .Restore(Restore), .OutA(OutA), .OutB(OutB)
    );

    param_register_file #(.WIDTH(16), .NUM_R(8), .NUM_S(2), .SELW(4)) dut6 (
        .Clock(Clock), .Reset(Reset), .I(b_I), .FunSel(b_FunSel), .RegSel(b_RegSel),
        .ScrSel(b_ScrSel), .OutASel(b_OutASel), .OutBSel(b_OutBSel), .Save(b_Save),
        .Restore(b_Restore), .OutA(b_OutA), .OutB(b_OutB)
    );

    // FunSel semantics in plain 32-bit arithmetic.
    function automatic logic [31:0] fop(input logic [2:0] f, input logic [31:0] q, input logic [31:0] i);
        case (f)
            3'd0:    return q - 32'd1;
            3'd1:    return q + 32'd1;
            3'd2:    return i;
            3'd3:    return 32'd0;
            3'd4:    return i & 32'h0000_00FF;
            3'd5:    return (q & 32'hFFFF_0000) | (i & 32'h0000_FFFF);
            3'd6:    return (q << 8) | (i & 32'h0000_00FF);
            default: return (i & 32'h8000) != 0 ? ((i & 32'hFFFF) | 32'hFFFF_0000) : (i & 32'hFFFF);
        endcase
    endfunction

    function automatic logic [31:0] model_rd(input int s);
        return (s < 4) ? mr[s] : ms[s-4];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 4; k++) begin
            mr[k] = '0; ms[k] = '0; msh[k] = '0;
        end
    endtask

    // One edge on the main DUT, with the model advanced from pre-edge state.
    task automatic cyc(input logic [3:0] rs, input logic [3:0] ss, input logic [2:0] fs,
                       input logic [31:0] i, input logic sv, input logic rt);
        logic [31:0] nr [4];
        logic [31:0] ns [4];
        logic [31:0] nsh [4];
        RegSel = rs; ScrSel = ss; FunSel = fs; I = i; Save = sv; Restore = rt;
        for (int k = 0; k < 4; k++) begin
            nr[k]  = rt ? msh[k] : (rs[3-k] ? fop(fs, mr[k], i) : mr[k]);
            ns[k]  = ss[3-k] ? fop(fs, ms[k], i) : ms[k];
            nsh[k] = sv ? mr[k] : msh[k];
        end
        @(posedge Clock);
        #1;
        for (int k = 0; k < 4; k++) begin
            mr[k] = nr[k]; ms[k] = ns[k]; msh[k] = nsh[k];
        end
        RegSel = '0; ScrSel = '0; Save = 1'b0; Restore = 1'b0;
    endtask

    task automatic check_all(input string tag);
        for (int s = 0; s < 8; s++) begin
            OutASel = 3'(s);
            OutBSel = 3'(7 - s);
            #1;
            chk($sformatf("%s A%0d", tag, s), OutA, model_rd(s));
            chk($sformatf("%s B%0d", tag, 7 - s), OutB, model_rd(7 - s));
        end
    endtask

    task automatic rd_chk(input string tag, input int sel, input logic [31:0] exp);
        OutASel = 3'(sel);
        #1;
        chk(tag, OutA, exp);
    endtask

    task automatic bcyc(input logic [7:0] rs, input logic [1:0] ss, input logic [2:0] fs, input logic [15:0] i);
        b_RegSel = rs; b_ScrSel = ss; b_FunSel = fs; b_I = i;
        @(posedge Clock);
        #1;
        b_RegSel = '0; b_ScrSel = '0;
    endtask

    task automatic bchk(input string tag, input int sel, input logic [15:0] exp);
        b_OutASel = 4'(sel);
        b_OutBSel = 4'(sel);
        #1;
        chk({tag, " A"}, {16'h0, b_OutA}, {16'h0, exp});
        chk({tag, " B"}, {16'h0, b_OutB}, {16'h0, exp});
    endtask

    initial begin
        Reset = 1'b1;
        I = '0; FunSel = '0; RegSel = '0; ScrSel = '0; OutASel = '0; OutBSel = '0;
        Save = 1'b0; Restore = 1'b0;
        b_I = '0; b_FunSel = '0; b_RegSel = '0; b_ScrSel = '0; b_OutASel = '0; b_OutBSel = '0;
        b_Save = 1'b0; b_Restore = 1'b0;
        model_clear();
        #1;
        check_all("reset");
        @(negedge Clock);
        Reset = 1'b0;

        // T1: async reset between edges clears R, S and shadow
        cyc(4'hF, 4'hF, 3'b010, 32'h1234_5678, 1'b0, 1'b0);
        cyc(4'h0, 4'h0, 3'b000, 32'h0, 1'b1, 1'b0);
        Reset = 1'b1;
        model_clear();
        #1;
        check_all("t1_async");
        Reset = 1'b0;
        cyc(4'h0, 4'h0, 3'b000, 32'h0, 1'b0, 1'b1);
        rd_chk("t1_shadow_r1", 0, 32'h0);

        // Reset held across an edge discards the pending write/save
        RegSel = 4'hF; ScrSel = 4'hF; FunSel = 3'b001; Save = 1'b1; Reset = 1'b1;
        @(posedge Clock);
        #1;
        check_all("t1_edge");
        Reset = 1'b0; RegSel = '0; ScrSel = '0; Save = 1'b0;

        // T2: mixed enables
        cyc(4'hF, 4'hF, 3'b010, 32'h1234_5678, 1'b0, 1'b0);
        cyc(4'b1010, 4'b0101, 3'b010, 32'h3456_7890, 1'b0, 1'b0);
        check_all("t2");
        rd_chk("t2_sel1", 1, 32'h1234_5678);
        rd_chk("t2_sel5", 5, 32'h3456_7890);

        // T3: wraps and byte/half ops
        cyc(4'b1000, 4'h0, 3'b010, 32'hFFFF_FFFF, 1'b0, 1'b0);
        cyc(4'b0100, 4'h0, 3'b011, 32'h0, 1'b0, 1'b0);
        cyc(4'b0010, 4'b1000, 3'b010, 32'hAABB_CCDD, 1'b0, 1'b0);
        cyc(4'b1000, 4'h0, 3'b001, 32'h0, 1'b0, 1'b0);
        cyc(4'b0100, 4'h0, 3'b000, 32'h0, 1'b0, 1'b0);
        cyc(4'b0010, 4'h0, 3'b110, 32'h0000_1234, 1'b0, 1'b0);
        rd_chk("t3_inc_wrap", 0, 32'h0);
        rd_chk("t3_dec_wrap", 1, 32'hFFFF_FFFF);
        rd_chk("t3_shift8", 2, 32'hBBCC_DD34);
        cyc(4'b0001, 4'b1000, 3'b101, 32'h0000_8001, 1'b0, 1'b0);
        rd_chk("t3_lowhalf", 4, 32'hAABB_8001);
        cyc(4'b0001, 4'h0, 3'b111, 32'h0000_8001, 1'b0, 1'b0);
        rd_chk("t3_sext", 3, 32'hFFFF_8001);
        cyc(4'b0001, 4'h0, 3'b100, 32'h1234_56A5, 1'b0, 1'b0);
        rd_chk("t3_byte", 3, 32'h0000_00A5);
        check_all("t3");

        // T4: save with concurrent write, restore overrides RegSel, S still written
        cyc(4'b1000, 4'h0, 3'b010, 32'd1, 1'b0, 1'b0);
        cyc(4'b0100, 4'h0, 3'b010, 32'd2, 1'b0, 1'b0);
        cyc(4'b0010, 4'h0, 3'b010, 32'd3, 1'b0, 1'b0);
        cyc(4'b0001, 4'h0, 3'b010, 32'd4, 1'b0, 1'b0);
        cyc(4'b1000, 4'h0, 3'b011, 32'h0, 1'b1, 1'b0);
        rd_chk("t4_save_r1", 0, 32'h0);
        cyc(4'hF, 4'b1000, 3'b010, 32'd9, 1'b0, 1'b0);
        cyc(4'hF, 4'b1000, 3'b001, 32'h0, 1'b0, 1'b1);
        rd_chk("t4_r1", 0, 32'd1);
        rd_chk("t4_r2", 1, 32'd2);
        rd_chk("t4_r3", 2, 32'd3);
        rd_chk("t4_r4", 3, 32'd4);
        rd_chk("t4_s1", 4, 32'd10);
        check_all("t4");

        // T5: swap then restore
        cyc(4'b1000, 4'h0, 3'b010, 32'd5, 1'b0, 1'b0);
        cyc(4'b0100, 4'h0, 3'b010, 32'd6, 1'b0, 1'b0);
        cyc(4'b0010, 4'h0, 3'b010, 32'd7, 1'b0, 1'b0);
        cyc(4'b0001, 4'h0, 3'b010, 32'd8, 1'b0, 1'b0);
        cyc(4'h0, 4'h0, 3'b000, 32'h0, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) rd_chk($sformatf("t5_swap_r%0d", k + 1), k, 32'(k + 1));
        cyc(4'h0, 4'h0, 3'b000, 32'h0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) rd_chk($sformatf("t5_rest_r%0d", k + 1), k, 32'(k + 5));

        // Hold with nothing enabled
        for (int n = 0; n < 3; n++) cyc(4'h0, 4'h0, 3'(n), 32'hDEAD_BEEF, 1'b0, 1'b0);
        check_all("hold");

        // Random traffic against the reference model
        for (int n = 0; n < 150; n++) begin
            cyc(4'($urandom), 4'($urandom), 3'($urandom_range(0, 7)), $urandom,
                $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            check_all($sformatf("rnd%0d", n));
        end

        // T6: 16-bit, 8 general, 2 scratch, 4-bit selects
        bcyc(8'hFF, 2'b11, 3'b010, 16'h1234);
        bcyc(8'h00, 2'b10, 3'b010, 16'hABCD);
        bchk("t6_sel8", 8, 16'hABCD);
        bchk("t6_sel9", 9, 16'h1234);
        bchk("t6_sel12", 12, 16'h0000);
        bchk("t6_sel7", 7, 16'h1234);
        bcyc(8'h80, 2'b00, 3'b111, 16'h8001);
        bchk("t6_sext", 0, 16'h8001);
        bcyc(8'h40, 2'b00, 3'b110, 16'h0056);
        bchk("t6_shift8", 1, 16'h3456);
        bcyc(8'h20, 2'b00, 3'b101, 16'hBEEF);
        bchk("t6_lowhalf", 2, 16'hBEEF);
        bcyc(8'h10, 2'b00, 3'b010, 16'hFFFF);
        bcyc(8'h10, 2'b00, 3'b001, 16'h0000);
        bchk("t6_inc_wrap", 3, 16'h0000);
        bcyc(8'hAA, 2'b00, 3'b010, 16'h5555);
        bchk("t6_r1", 0, 16'h5555);
        bchk("t6_r2", 1, 16'h3456);
        bchk("t6_r5", 4, 16'h5555);
        bchk("t6_r6", 5, 16'h1234);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
